// File: rtl/seq_alu_pkg.sv
// Shared opcode constants, FSM state encoding and small helpers for seq_alu.
package seq_alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLL  = 4'd6;
   localparam logic [3:0] OP_SRL  = 4'd7;
   localparam logic [3:0] OP_SRA  = 4'd8;
   localparam logic [3:0] OP_MUL  = 4'd9;
   localparam logic [3:0] OP_PASS = 4'd10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   // True for the three shift opcodes that iterate one bit per cycle.
   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result bundle of seq_alu.
// Handshake: a bundle moves on a rising clk edge where valid and ready are
// both high; a source holding valid keeps its bundle stable until it moves,
// and ready may be asserted independently of valid.
interface seq_alu_if
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;
   logic             overflow;
   logic             negative;
   logic             busy;
   state_t           dbg_state;

   modport slave (
      input  in_valid, op, a, b, cin, out_ready,
      output in_ready, out_valid, result, carry, zero, overflow, negative,
             busy, dbg_state
   );

   modport master (
      output in_valid, op, a, b, cin, out_ready,
      input  in_ready, out_valid, result, carry, zero, overflow, negative,
             busy, dbg_state
   );
endinterface

// File: rtl/seq_alu_addsub.sv
// Combinational A + (B ^ {sub}) + c_in core shared by ADD, SUB and SLT.
module alu_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_sub,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry,
   output logic             o_overflow
);
   logic [WIDTH-1:0] w_b;

   // Inverted B plus c_in=1 gives two's-complement subtraction.
   always_comb begin
      w_b                = i_b ^ {WIDTH{i_sub}};
      {o_carry, o_sum}   = {1'b0, i_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, i_cin};
      o_overflow         = (i_a[WIDTH-1] == w_b[WIDTH-1]) &&
                           (o_sum[WIDTH-1] != i_a[WIDTH-1]);
   end
endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, one-bit-per-cycle shifts
// and a WIDTH-step shift-add multiply, with flags and valid/ready bundles.
// Iterative ops do their first step on the accept edge, so an op needing
// n steps presents its result n-1 edges after acceptance.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic       clk,
   input logic       rst_n,
   seq_alu_if.slave  bus
);
   state_t             r_state;
   state_t             w_next;
   logic [3:0]         r_op;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [SHW-1:0]     r_cnt;
   logic [WIDTH-1:0]   r_result;
   logic               r_carry;
   logic               r_zero;
   logic               r_overflow;
   logic               r_negative;

   logic               w_accept;
   logic               w_load;
   logic               w_in_exec;
   logic [SHW-1:0]     w_amt;
   logic [3:0]         w_cur_op;
   logic [WIDTH-1:0]   w_sh_src;
   logic [WIDTH-1:0]   w_sh_out;
   logic [2*WIDTH-1:0] w_mul_acc_src;
   logic [2*WIDTH-1:0] w_mul_mcand_src;
   logic [WIDTH-1:0]   w_mul_mplier_src;
   logic [2*WIDTH-1:0] w_mul_sum;
   logic [WIDTH-1:0]   w_as_sum;
   logic               w_as_carry;
   logic               w_as_overflow;
   logic               w_as_sub;
   logic               w_as_cin;
   logic               w_lt;
   logic [WIDTH-1:0]   w_fin_result;
   logic               w_fin_carry;
   logic               w_fin_overflow;
   logic               w_fin_zero;
   logic               w_fin_negative;

   // One-bit shift step for the three shift opcodes.
   function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      case (op)
         OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
         OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
         default: r = {v[WIDTH-1], v[WIDTH-1:1]};
      endcase
      return r;
   endfunction

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .i_a        (bus.a),
      .i_b        (bus.b),
      .i_sub      (w_as_sub),
      .i_cin      (w_as_cin),
      .o_sum      (w_as_sum),
      .o_carry    (w_as_carry),
      .o_overflow (w_as_overflow)
   );

   // Step datapath: operands come from the bus on the accept edge and from the working registers in EXEC.
   always_comb begin
      w_accept         = (r_state == IDLE) && bus.in_valid;
      w_in_exec        = (r_state == EXEC);
      w_amt            = bus.b[SHW-1:0];
      w_as_sub         = (bus.op != OP_ADD);
      w_as_cin         = (bus.op == OP_ADD) ? bus.cin : 1'b1;
      w_lt             = w_as_sum[WIDTH-1] ^ w_as_overflow;
      w_cur_op         = w_in_exec ? r_op : bus.op;
      w_sh_src         = w_in_exec ? r_acc[WIDTH-1:0] : bus.a;
      w_sh_out         = shift_one(w_cur_op, w_sh_src);
      w_mul_acc_src    = w_in_exec ? r_acc : '0;
      w_mul_mcand_src  = w_in_exec ? r_mcand : {{WIDTH{1'b0}}, bus.a};
      w_mul_mplier_src = w_in_exec ? r_mplier : bus.b;
      w_mul_sum        = w_mul_acc_src + (w_mul_mplier_src[0] ? w_mul_mcand_src : '0);
   end

   // Final result and flags, valid on the edge where w_load is high.
   always_comb begin
      w_fin_result   = bus.a;
      w_fin_carry    = 1'b0;
      w_fin_overflow = 1'b0;
      if (w_in_exec) begin
         if (r_op == OP_MUL) begin
            w_fin_result = w_mul_sum[WIDTH-1:0];
            w_fin_carry  = |w_mul_sum[2*WIDTH-1:WIDTH];
         end else begin
            w_fin_result = w_sh_out;
         end
      end else begin
         case (bus.op)
            OP_ADD, OP_SUB: begin
               w_fin_result   = w_as_sum;
               w_fin_carry    = w_as_carry;
               w_fin_overflow = w_as_overflow;
            end
            OP_AND:  w_fin_result = bus.a & bus.b;
            OP_OR:   w_fin_result = bus.a | bus.b;
            OP_XOR:  w_fin_result = bus.a ^ bus.b;
            OP_SLT:  w_fin_result = {{(WIDTH-1){1'b0}}, w_lt};
            OP_SLL, OP_SRL, OP_SRA:
               w_fin_result = (w_amt == '0) ? bus.a : w_sh_out;
            default: w_fin_result = bus.a;
         endcase
      end
      w_fin_zero     = (w_fin_result == '0);
      w_fin_negative = w_fin_result[WIDTH-1];
   end

   // Next-state logic; w_load marks the edge that enters DONE with a fresh result.
   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.in_valid) begin
               if ((bus.op == OP_MUL) || (is_shift(bus.op) && (w_amt > SHW'(1)))) begin
                  w_next = EXEC;
               end else begin
                  w_next = DONE;
                  w_load = 1'b1;
               end
            end
         end
         EXEC: begin
            if (r_cnt == SHW'(1)) begin
               w_next = DONE;
               w_load = 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Working registers, step counter and the held result/flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op       <= '0;
         r_acc      <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_cnt      <= '0;
         r_result   <= '0;
         r_carry    <= 1'b0;
         r_zero     <= 1'b0;
         r_overflow <= 1'b0;
         r_negative <= 1'b0;
      end else begin
         if (w_accept) r_op <= bus.op;
         if (w_accept || w_in_exec) begin
            if (w_cur_op == OP_MUL) r_acc <= w_mul_sum;
            else                    r_acc <= {{WIDTH{1'b0}}, w_sh_out};
            r_mcand  <= w_mul_mcand_src << 1;
            r_mplier <= w_mul_mplier_src >> 1;
            if (w_in_exec)                r_cnt <= r_cnt - SHW'(1);
            else if (bus.op == OP_MUL)    r_cnt <= SHW'(WIDTH - 1);
            else                          r_cnt <= w_amt - SHW'(1);
         end
         if (w_load) begin
            r_result   <= w_fin_result;
            r_carry    <= w_fin_carry;
            r_zero     <= w_fin_zero;
            r_overflow <= w_fin_overflow;
            r_negative <= w_fin_negative;
         end
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.busy      = (r_state != IDLE);
   assign bus.dbg_state = r_state;
   assign bus.result    = r_result;
   assign bus.carry     = r_carry;
   assign bus.zero      = r_zero;
   assign bus.overflow  = r_overflow;
   assign bus.negative  = r_negative;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8) with an arithmetic reference model
// and a per-cycle compare process.
module tb_seq_alu;
   import seq_alu_pkg::*;

   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   seq_alu_if #(.WIDTH(W)) bus ();

   seq_alu #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: result, flags {c,z,v,n} and steps until out_valid
   function automatic void model_op(input logic [3:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic cin,
                                    output logic [W-1:0] r, output logic [3:0] f,
                                    output int lat);
      int ua, ub, sa, sb, t, s;
      logic c, v;
      ua = int'(a); ub = int'(b);
      sa = int'($signed(a)); sb = int'($signed(b));
      s = ub % W;
      c = 1'b0; v = 1'b0; lat = 1; r = a;
      case (op)
         OP_ADD: begin
            t = ua + ub + int'(cin); r = W'(t); c = (t > 255);
            t = sa + sb + int'(cin); v = (t > 127) || (t < -128);
         end
         OP_SUB: begin
            r = W'(ua - ub); c = (ua >= ub);
            t = sa - sb; v = (t > 127) || (t < -128);
         end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_SLT: r = (sa < sb) ? W'(1) : W'(0);
         OP_SLL: begin r = W'(ua << s); lat = (s == 0) ? 1 : s; end
         OP_SRL: begin r = W'(ua >> s); lat = (s == 0) ? 1 : s; end
         OP_SRA: begin r = W'($signed(a) >>> s); lat = (s == 0) ? 1 : s; end
         OP_MUL: begin t = ua * ub; r = W'(t); c = (t > 255); lat = W; end
         default: r = a;
      endcase
      f = {c, (r == '0), v, r[W-1]};
   endfunction

   // scoreboard state
   logic [W-1:0] exp_q[$];
   logic [3:0]   exp_f_q[$];
   bit           m_idle = 1'b1;
   bit           m_done = 1'b0;
   int           m_wait = 0;

   // model advance on each edge, following the bundle protocol
   always @(posedge clk or negedge rst_n) begin
      logic [W-1:0] r;
      logic [3:0]   f;
      int           lat;
      if (!rst_n) begin
         exp_q.delete(); exp_f_q.delete();
         m_idle = 1'b1; m_done = 1'b0; m_wait = 0;
      end else if (m_idle) begin
         if (bus.in_valid) begin
            model_op(bus.op, bus.a, bus.b, bus.cin, r, f, lat);
            exp_q.push_back(r); exp_f_q.push_back(f);
            m_idle = 1'b0;
            m_wait = lat - 1;
            m_done = (m_wait == 0);
         end
      end else if (!m_done) begin
         m_wait--;
         if (m_wait == 0) m_done = 1'b1;
      end else if (bus.out_ready) begin
         void'(exp_q.pop_front()); void'(exp_f_q.pop_front());
         m_idle = 1'b1; m_done = 1'b0;
      end
   end

   // compare process, away from the active edge
   always @(negedge clk) begin
      chk("cmp_out_valid", 32'(bus.out_valid), 32'(m_done));
      chk("cmp_in_ready", 32'(bus.in_ready), 32'(m_idle));
      chk("cmp_busy", 32'(bus.busy), 32'(!m_idle));
      if (!rst_n) begin
         chk("cmp_rst_result", 32'(bus.result), 32'(0));
         chk("cmp_rst_flags", 32'({bus.carry, bus.zero, bus.overflow, bus.negative}), 32'(0));
      end else if (m_done && exp_q.size() > 0) begin
         chk("cmp_result", 32'(bus.result), 32'(exp_q[0]));
         chk("cmp_flags", 32'({bus.carry, bus.zero, bus.overflow, bus.negative}),
             32'(exp_f_q[0]));
      end
   end

   // driver: one bundle with hand-computed expectations; starts and ends at posedge+#1, DUT idle
   task automatic run_op(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin,
                         input logic [W-1:0] e_res, input logic [3:0] e_f, input int e_lat);
      int lat;
      bus.op = op; bus.a = a; bus.b = b; bus.cin = cin; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         chk({nm, "_busy"}, 32'(bus.busy), 32'(1));
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, "_timeout"}, 32'(bus.out_valid), 32'(1));
      chk({nm, "_latency"}, 32'(lat), 32'(e_lat));
      chk({nm, "_result"}, 32'(bus.result), 32'(e_res));
      chk({nm, "_flags_czvn"}, 32'({bus.carry, bus.zero, bus.overflow, bus.negative}), 32'(e_f));
      @(posedge clk); #1;
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
      chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
      chk("rst_busy", 32'(bus.busy), 32'(0));
      chk("rst_result", 32'(bus.result), 32'(0));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      //                        op      a      b      cin  res    {c,z,v,n} lat
      run_op("add_ovf",  OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0011, 1);
      run_op("add_cin",  OP_ADD, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b1100, 1);
      run_op("add_both", OP_ADD, 8'h80, 8'h80, 1'b1, 8'h01, 4'b1010, 1);
      run_op("sub_eq",   OP_SUB, 8'h05, 8'h05, 1'b0, 8'h00, 4'b1100, 1);
      run_op("sub_ovf",  OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b1010, 1);
      run_op("sub_brw",  OP_SUB, 8'h01, 8'h02, 1'b0, 8'hFF, 4'b0001, 1);
      run_op("and",      OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000, 1);
      run_op("or",       OP_OR,  8'h0F, 8'hF0, 1'b0, 8'hFF, 4'b0001, 1);
      run_op("xor",      OP_XOR, 8'hAA, 8'hAA, 1'b0, 8'h00, 4'b0100, 1);
      run_op("slt",      OP_SLT, 8'hFE, 8'h01, 1'b0, 8'h01, 4'b0000, 1);
      run_op("slt_no",   OP_SLT, 8'h01, 8'hFE, 1'b0, 8'h00, 4'b0100, 1);
      run_op("sra3",     OP_SRA, 8'h80, 8'h03, 1'b0, 8'hF0, 4'b0001, 3);
      run_op("sra2",     OP_SRA, 8'h40, 8'h02, 1'b0, 8'h10, 4'b0000, 2);
      run_op("sll0",     OP_SLL, 8'h81, 8'h00, 1'b0, 8'h81, 4'b0001, 1);
      run_op("sll_mod",  OP_SLL, 8'h01, 8'h09, 1'b0, 8'h02, 4'b0000, 1);
      run_op("srl7",     OP_SRL, 8'h80, 8'h07, 1'b0, 8'h01, 4'b0000, 7);
      run_op("mul_hi",   OP_MUL, 8'h12, 8'h10, 1'b0, 8'h20, 4'b1000, 8);
      run_op("mul_lo",   OP_MUL, 8'h0F, 8'h03, 1'b0, 8'h2D, 4'b0000, 8);
      run_op("pass",     4'd12,  8'h55, 8'hFF, 1'b1, 8'h55, 4'b0000, 1);

      // backpressure: result held, second bundle ignored until consumed
      bus.out_ready = 1'b0;
      bus.op = OP_ADD; bus.a = 8'h01; bus.b = 8'h02; bus.cin = 1'b0; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", 32'(bus.out_valid), 32'(1));
         chk("bp_result", 32'(bus.result), 32'(8'h03));
         chk("bp_in_ready", 32'(bus.in_ready), 32'(0));
         if (i == 1) begin
            bus.op = OP_ADD; bus.a = 8'h10; bus.b = 8'h20; bus.in_valid = 1'b1;
         end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_in_ready", 32'(bus.in_ready), 32'(1));
      chk("bp_idle_out_valid", 32'(bus.out_valid), 32'(0));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("bp_second_valid", 32'(bus.out_valid), 32'(1));
      chk("bp_second_result", 32'(bus.result), 32'(8'h30));
      @(posedge clk); #1;

      // reset in the middle of a multiply
      bus.op = OP_MUL; bus.a = 8'h12; bus.b = 8'h10; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", 32'(bus.out_valid), 32'(0));
      chk("mrst_result", 32'(bus.result), 32'(0));
      chk("mrst_busy", 32'(bus.busy), 32'(0));
      chk("mrst_in_ready", 32'(bus.in_ready), 32'(1));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) cnt++;
      end
      chk("mrst_no_result", 32'(cnt), 32'(0));

      // normal operation after the aborted op
      run_op("post_rst", OP_ADD, 8'h10, 8'h22, 1'b0, 8'h32, 4'b0000, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle ALU with valid/ready handshakes on the input and output sides.
- Single-cycle ops: add with carry-in, subtract, logic, signed compare.
- Iterative ops: shifts at one bit per cycle and an unsigned shift-add multiply.
- Provides Carry/Zero/Overflow/Negative flags.
- Sits between an operand source and a result consumer in the datapath experiments. It is the clocked successor to the combinational adder/ALU.

Parameters:
WIDTH, 8, operand/result width in bits (>=4)
SHW, $clog2(WIDTH), width of shift-amount field taken from b

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand bundle valid
in_ready  output  1  block can accept a bundle
op  input  4  opcode (see Behaviour)
a  input  WIDTH  operand A
b  input  WIDTH  operand B; for shifts, the shift amount is b[SHW-1:0]
cin  input  1  carry-in, used by ADD only
out_valid  output  1  result bundle valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  result
carry  output  1  carry out / no-borrow / MUL high-half-nonzero
zero  output  1  result == 0
overflow  output  1  signed overflow
negative  output  1  result[WIDTH-1]
busy  output  1  state != IDLE

Behaviour:
- Reset is asynchronous and active-low on rst_n; the block has a single clock, clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, all flags 0, busy=0.
- Opcodes:
  - 0 ADD: A+B+cin
  - 1 SUB: A+~B+1
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLT: result={0..,signed A<B}
  - 6 SLL
  - 7 SRL
  - 8 SRA
  - 9 MUL: low WIDTH bits of unsigned A*B
  - 10-15 PASS: result=A
- FSM states: IDLE, EXEC, DONE.
  - IDLE: in_ready=1. On in_valid, latch op/a/b/cin; the accept edge is cycle 0.
  - Single-cycle ops (0-5, 10-15), and shifts with amount 0: go directly to DONE. Result and flags are registered at the accept edge, so out_valid=1 at cycle 1.
  - Shifts with amount s>0: enter EXEC and perform one 1-bit shift per cycle, tracked by a down-counter. Move to DONE after s shifts; out_valid at cycle s.
  - MUL: enter EXEC with a WIDTH-step shift-add on a 2*WIDTH accumulator; out_valid at cycle WIDTH.
  - DONE: out_valid=1, and result/flags are held stable until out_ready=1. On that edge return to IDLE.
- in_ready=1 only in IDLE. There is no overlap: a new bundle is accepted only after the previous result has been consumed. in_valid outside IDLE is ignored.
- Flags:
  - ADD/SUB: carry = bit WIDTH of the (WIDTH+1)-bit sum; for SUB this means no-borrow. overflow = (A msb == B' msb) && (result msb != A msb), where B' = B for ADD and ~B for SUB.
  - All other ops: carry=0 and overflow=0, except MUL, where carry=1 if the upper WIDTH bits of the product are nonzero.
  - zero and negative are computed from the final result for every op.
- SRA replicates the msb. Shift amount s is taken modulo 2^SHW.
- Reset asserted mid-operation aborts the op immediately: all state returns to reset values and no result is emitted.
- out_ready high while out_valid is low has no effect.

Decomposition:
- Package seq_alu_pkg holds:
  - opcode localparams OP_ADD..OP_PASS (4-bit)
  - state encoding IDLE/EXEC/DONE
- One natural sub-module: alu_addsub. It is a combinational WIDTH-bit A + (B^{WIDTH{sub}}) + c_in core producing sum, carry and overflow, and is reused for ADD, SUB and SLT (sign of A-B xor overflow).
- The shift and multiply datapaths stay inline in seq_alu.

Test Plan:
- WIDTH=8, ADD a=0x7F b=0x01 cin=0 -> at cycle 1: result=0x80, overflow=1, negative=1, carry=0, zero=0. ADD a=0xFF b=0x00 cin=1 -> result=0x00, carry=1, zero=1.
- SUB a=0x05 b=0x05 -> result=0x00, zero=1, carry=1. SUB a=0x80 b=0x01 -> result=0x7F, overflow=1. SLT a=0xFE b=0x01 -> result=0x01.
- SRA a=0x80 b=3 -> out_valid first high at cycle 3, result=0xF0, negative=1. SLL a=0x81 b=0 -> cycle 1, result=0x81.
- MUL a=0x12 b=0x10 -> out_valid first high at cycle 8, result=0x20, carry=1. MUL a=0x0F b=0x03 -> result=0x2D, carry=0. busy=1 throughout.
- Backpressure: hold out_ready=0 for 5 cycles after ADD 0x01+0x02. Required: result=0x03 held stable, in_ready=0, and a second in_valid is ignored. Raise out_ready -> IDLE the next cycle, then the second bundle is accepted.
- Reset mid-MUL: assert rst_n=0 at cycle 4 -> out_valid=0, result=0, busy=0, in_ready=1 immediately. No result is emitted after release.
